gpu_core_param: RTL and testbench
=================================

Name: gpu_core_param

Overview:
- Parametrised successor of the 16-entry in-order GPU core.
- Buffers a program streamed from the task scheduler (TS), then executes it one instruction at a time through a multi-cycle F/D/E/M/WB sequence. Loads and stores go to shared memory (SM) over a request/valid handshake.
- New over the previous generation:
  - Generic data width, instruction-buffer depth, SM address width and core ID.
  - Variable-length program load.
  - Defined divide-by-zero result.
  - Store data and write-enable valid together with the request.
  - 8-bit branch target.
  - HALT opcode.
  - Error flag.

Parameters:
- DATA_W, 8: register and SM data width (8..32).
- IMEM_DEPTH, 16: instruction buffer entries; power of two, 2..256. PC_W = clog2(IMEM_DEPTH).
- ADDR_W, 12: SM address width; must be greater than DATA_W.
- CORE_ID, 10: value returned by the CID instruction; also drives core_id.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- val_ins  in  1  instruction word valid from TS
- ins_last  in  1  marks the final word of the program; sampled with val_ins
- instruction  in  16  instruction word
- rtr  out  1  ready to receive instructions
- ready  out  1  program complete; held until the next accepted val_ins
- err  out  1  sticky; set on program overflow or an out-of-range branch; cleared by reset or by the next program load
- mem_req  out  1  SM request; held until val_data
- mem_we  out  1  1 = store, 0 = load; valid while mem_req is high
- addr_shared_memory  out  ADDR_W  SM address
- mem_dat_st  out  DATA_W  store data; valid while mem_req && mem_we
- mem_dat  in  DATA_W  load data; sampled on val_data
- val_data  in  1  SM completion
- core_id  out  4  constant CORE_ID

Behaviour:
- Reset values:
  - Outputs: rtr=1, ready=0, err=0, mem_req=0, mem_we=0, addr_shared_memory=0, mem_dat_st=0.
  - Internal: state=LOAD, PC=0, wr_ptr=0, prog_len=0, RF cleared.
  - Reset mid-operation aborts any SM transaction; mem_req drops immediately.
- Instruction format: op[15:12], rs1[11:8], rs2[7:4], rd[3:0]. RF has 16 entries of DATA_W bits.
- LOAD state:
  - Each cycle with val_ins && rtr: write the word to ibuf[wr_ptr], then increment wr_ptr. The first accepted word clears ready and err.
  - On ins_last, or when wr_ptr reaches IMEM_DEPTH-1: set prog_len = wr_ptr+1, rtr=0, PC=0, go to FETCH.
  - Words after a full buffer never arrive, because rtr drops in the same cycle the last entry is written. If the word that fills the buffer (wr_ptr = IMEM_DEPTH-1) does not carry ins_last, set err.
- Execution, one cycle per state: FETCH -> DECODE -> EXEC -> MEM -> WB -> FETCH.
  - Non-memory instruction: 5 cycles.
  - Memory instruction: 5 cycles plus the wait; MEM_WAIT is inserted between MEM and WB until val_data.
- FETCH: IR <= ibuf[PC].
- DECODE: A <= RF[rs1], B <= RF[rs2], S <= RF[rd].
- EXEC, all arithmetic truncated to DATA_W:
  - 1 add; 2 sub; 3 mul (low DATA_W bits).
  - 4 div: B==0 gives all-ones.
  - 5 cmpge: result is 1 or 0.
  - 6 shr, 7 shl: shift amount is B[clog2(DATA_W)-1:0].
  - 8 and; 9 or; 10 xor.
  - 11 ld, 13 st: address = {B, A} truncated to ADDR_W.
  - 12 ldi: rd <= zero-extend(IR[11:4]).
  - 0: nop, except rs1==4'hC, which is CID: rd <= CORE_ID.
  - 14 bnz: if A != 0, branch target = IR[11:4] truncated to PC_W. A target >= prog_len sets err and ends the program.
  - 15 halt.
- MEM: for ld/st, assert mem_req, set mem_we, drive the address and mem_dat_st = S, go to MEM_WAIT. Otherwise go to WB.
- MEM_WAIT: on val_data, deassert mem_req the next cycle and go to WB. For ld, capture mem_dat. val_data while mem_req is low is ignored.
- WB:
  - Write rd for ALU ops, ldi, CID and ld. Ops 13/14/15 and nop write nothing.
  - If op==15, or the branch was out of range, or (branch not taken and PC == prog_len-1): ready <= 1, rtr <= 1, wr_ptr <= 0, state <= LOAD. The buffer is not cleared.
  - Otherwise PC <= taken ? target : PC+1, then FETCH.
- A taken branch whose target is PC+1 behaves the same as fall-through.
- ready and rtr rise in the same cycle. A val_ins in that same cycle is not accepted; it is accepted from the following cycle.

Decomposition:
- Package gpu_core_pkg:
  - Opcode localparams (OP_NOP..OP_HALT), state enum, CID selector constant 4'hC.
  - Function div_safe(a,b).
- Sub-module gpu_alu (parameter DATA_W): combinational, handles ops 1-10; the core instantiates it once.

Test Plan:
- Basic ALU: load 3 words (ldi r1,5; ldi r2,3; add r3,r1,r2 with ins_last) -> r3=8; ready rises 15 cycles after the last load cycle; rtr=1.
- Division by zero and shift, DATA_W=8: div r4,r1,r0 with r0=0 -> r4=0xFF. shl of 0x81 by 9 (9 mod 8 = 1) -> 0x02.
- Memory handshake:
  - st r5 to {r7,r6}={0x3,0x21}: mem_req=1, mem_we=1, address 0x321, mem_dat_st=r5 all held through a 4-cycle val_data delay.
  - ld from the same address returns mem_dat=0xA5 -> rd=0xA5.
- Loop: counter decremented with bnz back to entry 1, three iterations -> exact cycle count 3x5 + setup. Branch to 0x20 with prog_len=4 -> err=1, ready=1.
- Overflow and halt: with IMEM_DEPTH=4, send 4 words without ins_last -> rtr drops after the 4th, err=1. A halt at entry 1 -> entries 2-3 never execute.
- Reset: assert reset during MEM_WAIT -> mem_req=0 in the same cycle, state=LOAD, rtr=1; a new program then runs correctly.

Source files
------------

// File: rtl/gpu_core_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the parametrised GPU core.
package gpu_core_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_MUL   = 4'd3;
    localparam logic [3:0] OP_DIV   = 4'd4;
    localparam logic [3:0] OP_CMPGE = 4'd5;
    localparam logic [3:0] OP_SHR   = 4'd6;
    localparam logic [3:0] OP_SHL   = 4'd7;
    localparam logic [3:0] OP_AND   = 4'd8;
    localparam logic [3:0] OP_OR    = 4'd9;
    localparam logic [3:0] OP_XOR   = 4'd10;
    localparam logic [3:0] OP_LD    = 4'd11;
    localparam logic [3:0] OP_LDI   = 4'd12;
    localparam logic [3:0] OP_ST    = 4'd13;
    localparam logic [3:0] OP_BNZ   = 4'd14;
    localparam logic [3:0] OP_HALT  = 4'd15;

    // rs1 value that turns an OP_NOP into CID
    localparam logic [3:0] CID_SEL  = 4'hC;

    typedef enum logic [2:0] {
        S_LOAD, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MEM_WAIT, S_WB
    } state_t;

    // Divide by zero yields all-ones; callers truncate to their data width
    function automatic logic [31:0] div_safe(input logic [31:0] a, input logic [31:0] b);
        return (b == '0) ? '1 : a / b;
    endfunction

endpackage

// File: rtl/gpu_core_if.sv
// Task-scheduler program stream and shared-memory request/valid bus.
interface gpu_ts_if;
    logic        val_ins;
    logic        ins_last;
    logic [15:0] instruction;
    logic        rtr;
    logic        ready;
    logic        err;

    modport master (output val_ins, ins_last, instruction, input rtr, ready, err);
    modport slave  (input val_ins, ins_last, instruction, output rtr, ready, err);
endinterface

interface gpu_sm_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 12
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] addr_shared_memory;
    logic [DATA_W-1:0] mem_dat_st;
    logic [DATA_W-1:0] mem_dat;
    logic              val_data;

    modport master (output mem_req, mem_we, addr_shared_memory, mem_dat_st,
                    input  mem_dat, val_data);
    modport slave  (input  mem_req, mem_we, addr_shared_memory, mem_dat_st,
                    output mem_dat, val_data);
endinterface

// File: rtl/gpu_core_alu.sv
// Combinational ALU for opcodes 1-10; other opcodes produce zero.
module gpu_alu
    import gpu_core_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y
);
    localparam int SH_W = $clog2(DATA_W);

    logic [SH_W-1:0] sh;
    assign sh = b[SH_W-1:0];

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:   y = a + b;
            OP_SUB:   y = a - b;
            OP_MUL:   y = a * b;
            OP_DIV:   y = DATA_W'(div_safe(32'(a), 32'(b)));
            OP_CMPGE: y = DATA_W'(a >= b);
            OP_SHR:   y = a >> sh;
            OP_SHL:   y = a << sh;
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            default:  y = '0;
        endcase
    end
endmodule

// File: rtl/gpu_core_param.sv
// In-order GPU core: buffers a streamed program, then runs it one
// instruction at a time through FETCH/DECODE/EXEC/MEM(/MEM_WAIT)/WB.
module gpu_core_param
    import gpu_core_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int IMEM_DEPTH = 16,
    parameter int ADDR_W     = 12,
    parameter int CORE_ID    = 10
) (
    input  logic       clk,
    input  logic       reset,
    gpu_ts_if.slave    ts,
    gpu_sm_if.master   sm,
    output logic [3:0] core_id
);
    localparam int PC_W = $clog2(IMEM_DEPTH);

    state_t            state, state_nx;
    logic [15:0]       ibuf [IMEM_DEPTH];
    logic [DATA_W-1:0] rf [16];
    logic [PC_W-1:0]   pc, wr_ptr;
    logic [PC_W:0]     prog_len;
    logic [15:0]       ir;
    logic [DATA_W-1:0] a, b, s, res, alu_y;
    logic              taken, oor;
    logic              rtr_q, ready_q, err_q;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dat_st_q;

    logic [3:0] op, rs1, rs2, rd;
    logic [7:0] imm;
    assign op  = ir[15:12];
    assign rs1 = ir[11:8];
    assign rs2 = ir[7:4];
    assign rd  = ir[3:0];
    assign imm = ir[11:4];

    logic accept, buf_full, load_done, is_mem, wr_rd, done;
    assign accept    = ts.val_ins && rtr_q && (state == S_LOAD);
    assign buf_full  = (wr_ptr == PC_W'(IMEM_DEPTH - 1));
    assign load_done = accept && (ts.ins_last || buf_full);
    assign is_mem    = (op == OP_LD) || (op == OP_ST);
    assign wr_rd     = (op >= OP_ADD && op <= OP_LDI) || (op == OP_NOP && rs1 == CID_SEL);
    // The last entry only ends the program when control falls through it
    assign done      = (op == OP_HALT) || oor ||
                       (!taken && ({1'b0, pc} == prog_len - 1'b1));

    gpu_alu #(.DATA_W(DATA_W)) u_alu (.op(op), .a(a), .b(b), .y(alu_y));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_LOAD;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_LOAD:     if (load_done) state_nx = S_FETCH;
            S_FETCH:    state_nx = S_DECODE;
            S_DECODE:   state_nx = S_EXEC;
            S_EXEC:     state_nx = S_MEM;
            S_MEM:      state_nx = is_mem ? S_MEM_WAIT : S_WB;
            S_MEM_WAIT: if (sm.val_data) state_nx = S_WB;
            S_WB:       state_nx = done ? S_LOAD : S_FETCH;
            default:    state_nx = S_LOAD;
        endcase
    end

    // Instruction buffer is deliberately not reset or cleared between programs
    always_ff @(posedge clk) begin
        if (accept) ibuf[wr_ptr] <= ts.instruction;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rtr_q     <= 1'b1;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            addr_q    <= '0;
            dat_st_q  <= '0;
            pc        <= '0;
            wr_ptr    <= '0;
            prog_len  <= '0;
            ir        <= '0;
            a         <= '0;
            b         <= '0;
            s         <= '0;
            res       <= '0;
            taken     <= 1'b0;
            oor       <= 1'b0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_LOAD: if (accept) begin
                    wr_ptr <= wr_ptr + PC_W'(1);
                    if (wr_ptr == '0) begin
                        ready_q <= 1'b0;
                        err_q   <= 1'b0;
                    end
                    if (load_done) begin
                        prog_len <= {1'b0, wr_ptr} + (PC_W+1)'(1);
                        rtr_q    <= 1'b0;
                        pc       <= '0;
                        if (!ts.ins_last) err_q <= 1'b1;
                    end
                end
                S_FETCH:  ir <= ibuf[pc];
                S_DECODE: begin
                    a <= rf[rs1];
                    b <= rf[rs2];
                    s <= rf[rd];
                end
                S_EXEC: begin
                    if (op == OP_LDI)      res <= DATA_W'(imm);
                    else if (op == OP_NOP) res <= (rs1 == CID_SEL) ? DATA_W'(CORE_ID) : '0;
                    else                   res <= alu_y;
                    taken <= (op == OP_BNZ) && (a != '0);
                    // Range check uses the full 8-bit target, before truncation to PC_W
                    oor   <= (op == OP_BNZ) && (a != '0) && (32'(imm) >= 32'(prog_len));
                end
                S_MEM: if (is_mem) begin
                    mem_req_q <= 1'b1;
                    mem_we_q  <= (op == OP_ST);
                    addr_q    <= ADDR_W'({b, a});
                    dat_st_q  <= s;
                end
                S_MEM_WAIT: if (sm.val_data) begin
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    if (op == OP_LD) res <= sm.mem_dat;
                end
                S_WB: begin
                    if (wr_rd) rf[rd] <= res;
                    if (done) begin
                        ready_q <= 1'b1;
                        rtr_q   <= 1'b1;
                        wr_ptr  <= '0;
                        if (oor) err_q <= 1'b1;
                    end else begin
                        pc <= taken ? imm[PC_W-1:0] : pc + PC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ts.rtr                = rtr_q;
    assign ts.ready              = ready_q;
    assign ts.err                = err_q;
    assign sm.mem_req            = mem_req_q;
    assign sm.mem_we             = mem_we_q;
    assign sm.addr_shared_memory = addr_q;
    assign sm.mem_dat_st         = dat_st_q;
    assign core_id               = 4'(CORE_ID);
endmodule

// File: tb/tb_gpu_core_param.sv
// Directed bench for gpu_core_param (IMEM_DEPTH=4) with a delayed SM responder.
module tb_gpu_core_param;
    import gpu_core_pkg::*;

    localparam int DW = 8, DEPTH = 4, AW = 12, CID = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] core_id;

    gpu_ts_if ts ();
    gpu_sm_if #(.DATA_W(DW), .ADDR_W(AW)) sm ();

    gpu_core_param #(.DATA_W(DW), .IMEM_DEPTH(DEPTH), .ADDR_W(AW), .CORE_ID(CID)) dut (
        .clk(clk), .reset(reset), .ts(ts), .sm(sm), .core_id(core_id)
    );

    always #5 clk = ~clk;

    int            n_pass = 0, n_chk = 0;
    int            sm_delay = 0, wait_cnt = 0;
    logic [DW-1:0] ld_data = '0;
    logic [12:0]   last_req = '0;
    logic [15:0]   pg [4];

    // SM responder: val_data after sm_delay negedges of an active request
    always @(negedge clk) begin
        sm.val_data = 1'b0;
        sm.mem_dat  = ld_data;
        if (sm.mem_req) begin
            if (wait_cnt == sm_delay) begin
                sm.val_data = 1'b1;
                last_req    = {sm.mem_we, sm.addr_shared_memory};
            end
            wait_cnt++;
        end else begin
            wait_cnt = 0;
        end
    end

    function automatic logic [15:0] ins(input int op, input int r1, input int r2, input int rd);
        return {op[3:0], r1[3:0], r2[3:0], rd[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic load(input int n, input logic last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ts.val_ins     = 1'b1;
            ts.instruction = pg[i];
            ts.ins_last    = last && (i == n - 1);
        end
        @(posedge clk); #1;
        ts.val_ins  = 1'b0;
        ts.ins_last = 1'b0;
    endtask

    // Cycles from the last load edge until ready is seen
    task automatic run(input string tag, output int cyc);
        bit seen = 0;
        cyc = 0;
        while (!seen && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            seen = ts.ready;
        end
        if (!seen) begin
            n_chk++;
            $error("FAIL %s_timeout: ready=%0b after %0d cycles, expected 1", tag, ts.ready, cyc);
        end
    endtask

    task automatic wait_req(input string tag);
        bit seen = 0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            seen = sm.mem_req;
        end
        if (!seen) begin
            n_chk++;
            $error("FAIL %s_req_timeout: mem_req=%0b expected 1", tag, sm.mem_req);
        end
    endtask

    initial begin
        int cyc;
        ts.val_ins = 1'b0; ts.ins_last = 1'b0; ts.instruction = '0;
        reset = 1'b1;
        #12;
        chk("rst_rtr", ts.rtr, 1);
        chk("rst_ready", ts.ready, 0);
        chk("rst_err", ts.err, 0);
        chk("rst_mem_req", sm.mem_req, 0);
        chk("rst_mem_we", sm.mem_we, 0);
        chk("rst_addr", sm.addr_shared_memory, 0);
        chk("rst_dat_st", sm.mem_dat_st, 0);
        chk("core_id", core_id, CID);
        @(negedge clk); reset = 1'b0;

        // ldi r1,5; ldi r2,3; add r3,r1,r2
        pg[0] = ins(12, 0, 5, 1); pg[1] = ins(12, 0, 3, 2); pg[2] = ins(1, 1, 2, 3);
        load(3, 1);
        chk("alu_rtr_low", ts.rtr, 0);
        run("alu", cyc);
        chk("alu_cycles", cyc, 15);
        chk("alu_r3", dut.rf[3], 8'h08);
        chk("alu_rtr_high", ts.rtr, 1);
        chk("alu_err", ts.err, 0);

        // ldi r1,0x81; ldi r2,9; div r4,r1,r0; shl r5,r1,r2 (fills buffer with ins_last)
        pg[0] = ins(12, 8, 1, 1); pg[1] = ins(12, 0, 9, 2);
        pg[2] = ins(4, 1, 0, 4);  pg[3] = ins(7, 1, 2, 5);
        load(4, 1);
        chk("div_ready_clr", ts.ready, 0);
        run("div", cyc);
        chk("div_cycles", cyc, 20);
        chk("div0_r4", dut.rf[4], 8'hFF);
        chk("shl_r5", dut.rf[5], 8'h02);
        chk("full_last_err", ts.err, 0);

        // ldi r6,0x21; ldi r7,3; st r5 -> {r7,r6}
        sm_delay = 4;
        pg[0] = ins(12, 2, 1, 6); pg[1] = ins(12, 0, 3, 7); pg[2] = ins(13, 6, 7, 5);
        load(3, 1);
        wait_req("st");
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("st_hold%0d", k),
                {sm.mem_req, sm.mem_we, sm.addr_shared_memory, sm.mem_dat_st},
                {1'b1, 1'b1, 12'h321, 8'h02});
            @(negedge clk);
        end
        chk("st_req_drop", sm.mem_req, 0);
        run("st", cyc);
        chk("st_err", ts.err, 0);

        // ld r8 <- {r7,r6}
        sm_delay = 2; ld_data = 8'hA5;
        pg[0] = ins(11, 6, 7, 8);
        load(1, 1);
        run("ld", cyc);
        chk("ld_cycles", cyc, 8);
        chk("ld_r8", dut.rf[8], 8'hA5);
        chk("ld_req", last_req, {1'b0, 12'h321});

        // ldi r0,3; ldi r2,1; sub r0,r0,r2; bnz r0 -> 1
        pg[0] = ins(12, 0, 3, 0); pg[1] = ins(12, 0, 1, 2);
        pg[2] = ins(2, 0, 2, 0);  pg[3] = ins(14, 0, 1, 0);
        load(4, 1);
        run("loop", cyc);
        chk("loop_cycles", cyc, 50);
        chk("loop_r0", dut.rf[0], 8'h00);

        // ldi r2,1; cid r9; bnz r2 -> 0x20 (out of range); ldi r10,0x77
        pg[0] = ins(12, 0, 1, 2); pg[1] = ins(0, 12, 0, 9);
        pg[2] = ins(14, 2, 0, 0); pg[3] = ins(12, 7, 7, 10);
        load(4, 1);
        run("oor", cyc);
        chk("oor_cycles", cyc, 15);
        chk("oor_err", ts.err, 1);
        chk("cid_r9", dut.rf[9], CID);
        chk("oor_r10", dut.rf[10], 8'h00);

        // ldi r12,0x12; halt; ldi r12,0x34; ldi r13,0x56
        pg[0] = ins(12, 1, 2, 12); pg[1] = ins(15, 0, 0, 0);
        pg[2] = ins(12, 3, 4, 12); pg[3] = ins(12, 5, 6, 13);
        load(4, 1);
        chk("halt_err_clr", ts.err, 0);
        run("halt", cyc);
        chk("halt_cycles", cyc, 10);
        chk("halt_r12", dut.rf[12], 8'h12);
        chk("halt_r13", dut.rf[13], 8'h00);

        // four words, no ins_last: overflow
        for (int k = 0; k < 4; k++) pg[k] = ins(12, 0, k + 1, 11);
        load(4, 0);
        chk("ovf_rtr", ts.rtr, 0);
        chk("ovf_err", ts.err, 1);
        run("ovf", cyc);
        chk("ovf_cycles", cyc, 20);
        chk("ovf_r11", dut.rf[11], 8'h04);

        // reset while waiting on SM
        sm_delay = 1000;
        pg[0] = ins(11, 6, 7, 14);
        load(1, 1);
        wait_req("rst");
        #2 reset = 1'b1;
        #1;
        chk("mrst_mem_req", sm.mem_req, 0);
        chk("mrst_rtr", ts.rtr, 1);
        chk("mrst_state", 32'(dut.state), 32'(S_LOAD));
        chk("mrst_r5", dut.rf[5], 8'h00);
        @(negedge clk); reset = 1'b0; sm_delay = 0;
        pg[0] = ins(12, 0, 5, 1); pg[1] = ins(12, 0, 3, 2); pg[2] = ins(1, 1, 2, 3);
        load(3, 1);
        run("post_rst", cyc);
        chk("post_rst_cycles", cyc, 15);
        chk("post_rst_r3", dut.rf[3], 8'h08);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
